// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 7-digit common-anode seven-segment display.
// Each digit slot starts dark for BLANK cycles, then lights under 16-step PWM dimming.
module seg7_scan_driver #(
    parameter int DIV   = 50000,
    parameter int BLANK = 500
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic [55:0] SEG_IN,
    input  logic [3:0]  BRIGHT,
    output logic [7:0]  SEG_OUT,
    output logic [6:0]  DIG_SEL,
    output logic        FRAME_TICK
);

    localparam int SW = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_ON    = 2'd2;

    // With no blanking interval a slot begins directly in the lit phase.
    localparam logic [1:0]    ST_START  = (BLANK == 0) ? ST_ON : ST_BLANK;
    localparam logic [SW-1:0] SLOT_LAST = SW'(DIV - 1);
    localparam logic [SW-1:0] BLANK_END = SW'(BLANK);
    localparam logic [2:0]    IDX_LAST  = 3'd6;

    logic [1:0]    state;
    logic [SW-1:0] slot;
    logic [SW-1:0] slot_inc;
    logic [2:0]    idx;
    logic [3:0]    pwm;
    logic [55:0]   snap;
    logic          lit;

    assign slot_inc = slot + 1'b1;
    assign lit      = (state == ST_ON) && (pwm <= BRIGHT);

    // Outputs are registered from the current state, so they trail it by one cycle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            SEG_OUT <= 8'hFF;
            DIG_SEL <= 7'h7F;
        end else if (lit) begin
            SEG_OUT <= ~snap[{idx, 3'b000} +: 8];
            DIG_SEL <= ~(7'b000_0001 << idx);
        end else begin
            SEG_OUT <= 8'hFF;
            DIG_SEL <= 7'h7F;
        end
    end

    // Scan sequencer; dropping ENABLE wins over any slot advance or frame wrap.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= ST_IDLE;
            slot       <= '0;
            idx        <= '0;
            pwm        <= '0;
            snap       <= '0;
            FRAME_TICK <= 1'b0;
        end else begin
            FRAME_TICK <= 1'b0;
            if (!ENABLE) begin
                state <= ST_IDLE;
                slot  <= '0;
                idx   <= '0;
                pwm   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_START;
                        slot  <= '0;
                        idx   <= '0;
                        pwm   <= '0;
                        snap  <= SEG_IN;
                    end
                    ST_BLANK: begin
                        slot <= slot_inc;
                        if (slot_inc == BLANK_END) begin
                            state <= ST_ON;
                        end
                    end
                    ST_ON: begin
                        if (slot == SLOT_LAST) begin
                            state <= ST_START;
                            slot  <= '0;
                            pwm   <= '0;
                            if (idx == IDX_LAST) begin
                                idx        <= '0;
                                snap       <= SEG_IN;
                                FRAME_TICK <= 1'b1;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end else begin
                            slot <= slot_inc;
                            pwm  <= pwm + 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        slot  <= '0;
                        idx   <= '0;
                        pwm   <= '0;
                    end
                endcase
            end
        end
    end

endmodule
